// File: rtl/data_path.sv
// 8-bit datapath: IR/MAR/PC/A/B/CCR registers, ALU and the two bus muxes.
// Clk/Reset(async low); strobes+selects in; IR, CCR_Result, address, to_memory out.
module data_path #(
  parameter int                 WIDTH    = 8,
  parameter logic [WIDTH-1:0]   PC_RESET = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             IR_Load,
  input  logic             MAR_Load,
  input  logic             PC_Load,
  input  logic             PC_Inc,
  input  logic             A_Load,
  input  logic             B_Load,
  input  logic             CCR_Load,
  input  logic [2:0]       ALU_Sel,
  input  logic [1:0]       Bus1_Sel,
  input  logic [1:0]       Bus2_Sel,
  input  logic [WIDTH-1:0] from_memory,
  output logic [WIDTH-1:0] IR,
  output logic [3:0]       CCR_Result,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] to_memory
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_INC  = 3'b100,
    OP_DEC  = 3'b101,
    OP_XOR  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  alu_op_e alu_op;
  assign alu_op = alu_op_e'(ALU_Sel);

  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] mar_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ccr_q;

  logic [WIDTH-1:0] bus1;
  logic [WIDTH-1:0] bus2;

  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic             alu_c;
  logic             alu_n;
  logic             alu_z;
  logic [3:0]       ccr_next;

  always_comb begin
    bus1 = '0;
    unique case (Bus1_Sel)
      2'b00:   bus1 = pc_q;
      2'b01:   bus1 = a_q;
      2'b10:   bus1 = b_q;
      default: bus1 = '0;
    endcase
  end

  // INC/DEC reuse the add/subtract paths with a constant 1 operand,
  // so their carry/overflow follow exactly the ADD/SUB rules.
  always_comb begin
    opnd    = b_q;
    wide    = '0;
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    unique case (alu_op)
      OP_ADD, OP_INC: begin
        if (alu_op == OP_INC) opnd = ONE;
        wide    = {1'b0, bus1} + {1'b0, opnd};
        alu_res = wide[MSB:0];
        alu_c   = wide[WIDTH];
        alu_v   = (bus1[MSB] == opnd[MSB]) &&
                  (alu_res[MSB] != bus1[MSB]);
      end
      OP_SUB, OP_DEC: begin
        if (alu_op == OP_DEC) opnd = ONE;
        // Top bit of the widened difference is the unsigned borrow.
        wide    = {1'b0, bus1} - {1'b0, opnd};
        alu_res = wide[MSB:0];
        alu_c   = wide[WIDTH];
        alu_v   = (bus1[MSB] != opnd[MSB]) &&
                  (alu_res[MSB] != bus1[MSB]);
      end
      OP_AND:  alu_res = bus1 & b_q;
      OP_OR:   alu_res = bus1 | b_q;
      OP_XOR:  alu_res = bus1 ^ b_q;
      OP_PASS: alu_res = bus1;
      default: alu_res = '0;
    endcase
  end

  assign alu_n = alu_res[MSB];
  assign alu_z = (alu_res == '0);

  always_comb begin
    bus2 = '0;
    unique case (Bus2_Sel)
      2'b00:   bus2 = alu_res;
      2'b01:   bus2 = bus1;
      2'b10:   bus2 = from_memory;
      default: bus2 = '0;
    endcase
  end

  // Non-ALU transfers still set N/Z so loads can feed branches.
  always_comb begin
    ccr_next = {bus2[MSB], (bus2 == '0), 2'b00};
    if (Bus2_Sel == 2'b00)
      ccr_next = {alu_n, alu_z, alu_v, alu_c};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ir_q  <= '0;
      mar_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      ccr_q <= '0;
    end else begin
      if (IR_Load)  ir_q  <= bus2;
      if (MAR_Load) mar_q <= bus2;
      if (A_Load)   a_q   <= bus2;
      if (B_Load)   b_q   <= bus2;
      if (CCR_Load) ccr_q <= ccr_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)       pc_q <= PC_RESET;
    else if (PC_Load) pc_q <= bus2;
    else if (PC_Inc)  pc_q <= pc_q + ONE;
  end

  assign IR         = ir_q;
  assign CCR_Result = ccr_q;
  assign address    = mar_q;
  assign to_memory  = bus1;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path.
// Registers are observed through to_memory by steering Bus1.
module tb_data_path;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc;
  logic       A_Load, B_Load, CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic [7:0] from_memory;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic [7:0] address;
  logic [7:0] to_memory;

  int total = 0;
  int bad   = 0;

  data_path #(.WIDTH(8), .PC_RESET(8'h00)) dut (
    .Clk(Clk), .Reset(Reset),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load),
    .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load),
    .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
    .from_memory(from_memory), .IR(IR),
    .CCR_Result(CCR_Result), .address(address),
    .to_memory(to_memory)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    IR_Load = 0; MAR_Load = 0; PC_Load = 0;
    PC_Inc = 0; A_Load = 0; B_Load = 0;
    CCR_Load = 0; ALU_Sel = 3'b000;
    Bus1_Sel = 2'b00; Bus2_Sel = 2'b00;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    idle();
  endtask

  task automatic rd(input logic [1:0] sel,
                    output logic [7:0] v);
    Bus1_Sel = sel;
    #1;
    v = to_memory;
  endtask

  task automatic chk_pc(input string t, input logic [7:0] e);
    logic [7:0] v;
    rd(2'b00, v); chk(t, v, e);
  endtask

  task automatic chk_a(input string t, input logic [7:0] e);
    logic [7:0] v;
    rd(2'b01, v); chk(t, v, e);
  endtask

  task automatic chk_b(input string t, input logic [7:0] e);
    logic [7:0] v;
    rd(2'b10, v); chk(t, v, e);
  endtask

  task automatic chk_ccr(input string t, input logic [3:0] e);
    chk(t, {4'h0, CCR_Result}, {4'h0, e});
  endtask

  task automatic ld_a(input logic [7:0] d);
    from_memory = d; Bus2_Sel = 2'b10; A_Load = 1; tick();
  endtask

  task automatic ld_b(input logic [7:0] d);
    from_memory = d; Bus2_Sel = 2'b10; B_Load = 1; tick();
  endtask

  task automatic ld_pc(input logic [7:0] d);
    from_memory = d; Bus2_Sel = 2'b10; PC_Load = 1; tick();
  endtask

  task automatic alu_a(input logic [2:0] op);
    ALU_Sel = op; Bus1_Sel = 2'b01; Bus2_Sel = 2'b00;
    A_Load = 1; CCR_Load = 1; tick();
  endtask

  initial begin
    idle();
    from_memory = 8'h00;
    Reset = 1'b0;
    #2;
    chk("rst_ir", IR, 8'h00);
    chk("rst_mar", address, 8'h00);
    chk_ccr("rst_ccr", 4'b0000);
    chk_pc("rst_pc", 8'h00);
    chk_a("rst_a", 8'h00);
    chk_b("rst_b", 8'h00);
    @(posedge Clk); #1;
    Reset = 1'b1;

    ld_a(8'h5A);
    ld_pc(8'h23);
    chk_a("pre_a", 8'h5A);
    chk_pc("pre_pc", 8'h23);
    idle();
    #1 Reset = 1'b0;
    #1;
    chk_a("async_a", 8'h00);
    chk_pc("async_pc", 8'h00);
    #1 Reset = 1'b1;
    idle();
    PC_Inc = 1; tick();
    PC_Inc = 1; tick();
    PC_Inc = 1; tick();
    chk_pc("inc3", 8'h03);

    #1 Reset = 1'b0;
    #1 Reset = 1'b1;
    idle();
    from_memory = 8'h11;
    Bus1_Sel = 2'b00; Bus2_Sel = 2'b01;
    MAR_Load = 1; tick();
    chk("fetch_mar", address, 8'h00);
    from_memory = 8'h11;
    Bus2_Sel = 2'b10; IR_Load = 1; PC_Inc = 1; tick();
    chk("fetch_ir", IR, 8'h11);
    chk_pc("fetch_pc", 8'h01);

    ld_a(8'h7F);
    ld_b(8'h01);
    alu_a(3'b000);
    chk_a("add_ovf_a", 8'h80);
    chk_ccr("add_ovf_ccr", 4'b1010);

    ld_a(8'hFF);
    alu_a(3'b000);
    chk_a("add_cz_a", 8'h00);
    chk_ccr("add_cz_ccr", 4'b0101);

    ld_b(8'h00);
    Bus1_Sel = 2'b10; Bus2_Sel = 2'b01;
    A_Load = 1; CCR_Load = 1; tick();
    chk_a("lda_a", 8'h00);
    chk_ccr("lda_ccr", 4'b0100);

    ld_pc(8'hFF);
    PC_Inc = 1; tick();
    chk_pc("pc_wrap", 8'h00);
    from_memory = 8'h40; Bus2_Sel = 2'b10;
    PC_Inc = 1; PC_Load = 1; tick();
    chk_pc("pc_prio", 8'h40);

    ld_a(8'h3C);
    Bus1_Sel = 2'b01;
    #1;
    chk("wr_data", to_memory, 8'h3C);
    idle();
    ld_b(8'hAA);
    Bus1_Sel = 2'b11; Bus2_Sel = 2'b11;
    B_Load = 1; tick();
    chk_b("b_zero", 8'h00);

    ld_a(8'h05);
    ld_b(8'h0A);
    alu_a(3'b001);
    chk_a("sub_a", 8'hFB);
    chk_ccr("sub_ccr", 4'b1001);

    ld_a(8'h80);
    ld_b(8'h01);
    alu_a(3'b001);
    chk_a("sub_ovf_a", 8'h7F);
    chk_ccr("sub_ovf_ccr", 4'b0010);

    alu_a(3'b100);
    chk_a("inc_a", 8'h80);
    chk_ccr("inc_ccr", 4'b1010);

    ld_a(8'h00);
    alu_a(3'b101);
    chk_a("dec_a", 8'hFF);
    chk_ccr("dec_ccr", 4'b1001);

    ld_b(8'h0F);
    alu_a(3'b010);
    chk_a("and_a", 8'h0F);
    chk_ccr("and_ccr", 4'b0000);

    ld_b(8'hF0);
    alu_a(3'b011);
    chk_a("or_a", 8'hFF);
    chk_ccr("or_ccr", 4'b1000);

    from_memory = 8'h5A; Bus2_Sel = 2'b10;
    A_Load = 1; B_Load = 1; tick();
    alu_a(3'b110);
    chk_a("xor_a", 8'h00);
    chk_ccr("xor_ccr", 4'b0100);

    ld_a(8'h81);
    alu_a(3'b111);
    chk_a("pass_a", 8'h81);
    chk_ccr("pass_ccr", 4'b1000);

    tick();
    tick();
    chk_a("hold_a", 8'h81);
    chk_b("hold_b", 8'h5A);
    chk_ccr("hold_ccr", 4'b1000);

    from_memory = 8'h80; Bus2_Sel = 2'b10;
    CCR_Load = 1; tick();
    chk_ccr("mem_ccr", 4'b1000);
    from_memory = 8'h00; Bus2_Sel = 2'b10;
    CCR_Load = 1; tick();
    chk_ccr("mem_z_ccr", 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
